// File: rtl/icache_axi_bridge.sv
// icache line-refill responder: one 128-bit line read becomes a 4-beat, 32-bit AXI INCR burst.
// Define ICACHE_BRIDGE_RRESP_CHK_EN to add dev_rerr (rresp[1] / missing-rlast summary per line).
module icache_axi_bridge #(
  parameter logic [3:0] ARID_VAL = 4'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [3:0]   cpu_ren,
  input  logic [31:0]  cpu_raddr,
  output logic         dev_rrdy,
  output logic         dev_rvalid,
  output logic [127:0] dev_rdata,
`ifdef ICACHE_BRIDGE_RRESP_CHK_EN
  output logic         dev_rerr,
`endif
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

  state_t         state_q, state_d;
  logic           rrdy_q;
  logic           drop_q;
  logic [1:0]     cnt_q;
  logic [27:0]    addr_q;
  logic [127:0]   line_q;
  logic           accept;
  logic           ar_hs;
  logic           r_hs;

  // rrdy_q gates acceptance so the first cycle out of reset cannot start a burst
  assign accept = (state_q == IDLE) && rrdy_q && (cpu_ren != 4'h0) && !flush;
  assign ar_hs  = (state_q == AR) && arready;
  assign r_hs   = (state_q == R) && rvalid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = AR;
      AR:      if (arready) state_d = R;
      R:       if (rvalid && (cnt_q == 2'd3)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rrdy_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      rrdy_q  <= (state_d == IDLE);
      if (accept) begin
        addr_q <= cpu_raddr[31:4];
        drop_q <= 1'b0;
      end else if (flush && (state_q != IDLE)) begin
        drop_q <= 1'b1;
      end
      if (ar_hs) cnt_q <= '0;
      else if (r_hs) cnt_q <= cnt_q + 2'd1;
      if (r_hs) line_q[{cnt_q, 5'd0} +: 32] <= rdata;
    end
  end

  assign dev_rrdy   = rrdy_q;
  assign dev_rvalid = (state_q == RESP) && !drop_q && !flush;
  assign dev_rdata  = line_q;
  assign arid       = ARID_VAL;
  assign araddr     = {addr_q, 4'h0};
  assign arlen      = 8'd3;
  assign arsize     = 3'b010;
  assign arburst    = 2'b01;
  assign arvalid    = (state_q == AR);
  assign rready     = (state_q == R);

`ifdef ICACHE_BRIDGE_RRESP_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (r_hs) begin
      err_q <= err_q | rresp[1] | ((cnt_q == 2'd3) && !rlast);
    end
  end

  assign dev_rerr = dev_rvalid && err_q;

  logic [7:0] unused_in;
  assign unused_in = {rid, cpu_raddr[3:0]};
`else
  logic [10:0] unused_in;
  assign unused_in = {rid, rresp, rlast, cpu_raddr[3:0]};
`endif

endmodule

// File: tb/tb_icache_axi_bridge.sv
// Randomized bench for icache_axi_bridge: the bench plays the AXI slave and
// predicts latency, line contents and pulse suppression from the burst shape.
module tb_icache_axi_bridge;

  localparam logic [3:0] ARID_TB = 4'hA;

  logic         clk = 1'b0;
  logic         rst, flush;
  logic [3:0]   cpu_ren;
  logic [31:0]  cpu_raddr;
  logic         dev_rrdy, dev_rvalid;
  logic [127:0] dev_rdata;
`ifdef ICACHE_BRIDGE_RRESP_CHK_EN
  logic         dev_rerr;
`endif
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  int checks = 0;
  int failures = 0;

  // per-refill stimulus shape
  logic [31:0]  beat_data[4];
  logic [1:0]   beat_resp[4];
  int           gap_cfg[4];

  // per-refill observations
  int           obs_pulses, obs_rv_cyc, obs_rrdy_cyc;
  int           obs_ar_bad, obs_rready_bad, obs_rrdy_bad;
  bit           obs_timeout;
  logic [127:0] obs_data, obs_final;
  logic         obs_rerr;

  icache_axi_bridge #(.ARID_VAL(ARID_TB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr),
    .dev_rrdy(dev_rrdy), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
`ifdef ICACHE_BRIDGE_RRESP_CHK_EN
    .dev_rerr(dev_rerr),
`endif
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] expected_line();
    return {beat_data[3], beat_data[2], beat_data[1], beat_data[0]};
  endfunction

  function automatic int expected_latency(input int ar_wait);
    return 6 + ar_wait + gap_cfg[0] + gap_cfg[1] + gap_cfg[2] + gap_cfg[3];
  endfunction

  // Cycle k (k>=1) is observed #1 after the k-th falling edge following the request cycle.
  task automatic run_refill(input logic [31:0] addr, input int ar_wait, input int flush_after);
    int arw = 0;
    int beat = 0;
    int gapc = 0;
    bit ar_done = 0;
    bit done = 0;
    bit flush_pending;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:4], 4'h0};
    obs_pulses = 0; obs_rv_cyc = -1; obs_rrdy_cyc = -1;
    obs_ar_bad = 0; obs_rready_bad = 0; obs_rrdy_bad = 0;
    obs_data = '0; obs_final = '0; obs_rerr = 1'b0;
    flush_pending = (flush_after == 0);
    @(negedge clk);
    #1;
    if (!dev_rrdy) obs_rrdy_bad++;
    cpu_ren = 4'hF;
    cpu_raddr = addr;
    for (int k = 1; k <= 100 && !done; k++) begin
      @(negedge clk);
      cpu_ren = '0;
      cpu_raddr = $urandom;
      flush = flush_pending;
      flush_pending = 0;
      arready = 1'b0;
      rvalid = 1'b0;
      rdata = $urandom;
      rresp = 2'b00;
      rlast = 1'b0;
      rid = 4'($urandom);
      #1;
      if (dev_rvalid) begin
        obs_pulses++;
        if (obs_rv_cyc < 0) begin
          obs_rv_cyc = k;
          obs_data = dev_rdata;
`ifdef ICACHE_BRIDGE_RRESP_CHK_EN
          obs_rerr = dev_rerr;
`endif
        end
      end
      if (beat == 4 && dev_rrdy) begin
        obs_rrdy_cyc = k;
        obs_final = dev_rdata;
        done = 1;
      end else begin
        if (dev_rrdy) obs_rrdy_bad++;
        if (!ar_done) begin
          if (!arvalid || araddr !== exp_addr || arlen !== 8'd3 || arsize !== 3'b010 ||
              arburst !== 2'b01 || arid !== ARID_TB) obs_ar_bad++;
          if (rready) obs_rready_bad++;
          if (arw >= ar_wait) begin
            arready = 1'b1;
            ar_done = 1;
          end else begin
            arw++;
          end
        end else if (beat < 4) begin
          if (!rready || arvalid) obs_rready_bad++;
          if (gapc < gap_cfg[beat]) begin
            gapc++;
          end else begin
            rvalid = 1'b1;
            rdata = beat_data[beat];
            rresp = beat_resp[beat];
            rlast = (beat == 3);
            beat++;
            gapc = 0;
            if (beat == flush_after) flush_pending = 1;
          end
        end else if (rready || arvalid) begin
          obs_rready_bad++;
        end
      end
    end
    obs_timeout = !done;
    flush = 1'b0;
  endtask

  task automatic clear_shape();
    for (int j = 0; j < 4; j++) begin
      gap_cfg[j] = 0;
      beat_resp[j] = 2'b00;
      beat_data[j] = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (dev_rrdy !== 1'b0) begin failures++; $display("FAIL reset_rrdy: got %b want 0", dev_rrdy); end
    checks++; if (dev_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b want 0", dev_rvalid); end
    checks++; if (dev_rdata !== 128'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", dev_rdata); end
    checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin failures++; $display("FAIL reset_handshake: got arvalid=%b rready=%b want 0 0", arvalid, rready); end
    checks++; if (araddr !== 32'h0) begin failures++; $display("FAIL reset_araddr: got %h want 0", araddr); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (dev_rrdy !== 1'b1) begin failures++; $display("FAIL reset_release_rrdy: got %b want 1", dev_rrdy); end
  endtask

  task automatic test_basic();
    clear_shape();
    beat_data[0] = 32'h11111111; beat_data[1] = 32'h22222222;
    beat_data[2] = 32'h33333333; beat_data[3] = 32'h44444444;
    run_refill(32'h1C00_0034, 0, -1);
    checks++; if (obs_timeout || obs_ar_bad != 0 || obs_rready_bad != 0 || obs_rrdy_bad != 0) begin
      failures++; $display("FAIL basic_protocol: got timeout=%0d ar_bad=%0d rready_bad=%0d rrdy_bad=%0d want all 0", obs_timeout, obs_ar_bad, obs_rready_bad, obs_rrdy_bad); end
    checks++; if (obs_rv_cyc != 6) begin failures++; $display("FAIL basic_latency: got %0d want 6", obs_rv_cyc); end
    checks++; if (obs_data !== 128'h44444444_33333333_22222222_11111111) begin
      failures++; $display("FAIL basic_data: got %h want 44444444333333332222222211111111", obs_data); end
    checks++; if (obs_pulses != 1) begin failures++; $display("FAIL basic_pulses: got %0d want 1", obs_pulses); end
    checks++; if (obs_rrdy_cyc != 7) begin failures++; $display("FAIL basic_rrdy_return: got %0d want 7", obs_rrdy_cyc); end
  endtask

  task automatic test_backpressure();
    clear_shape();
    gap_cfg[1] = 2;
    run_refill(32'h8000_F00C, 3, -1);
    checks++; if (obs_timeout || obs_ar_bad != 0 || obs_rready_bad != 0) begin
      failures++; $display("FAIL bp_protocol: got timeout=%0d ar_bad=%0d rready_bad=%0d want 0", obs_timeout, obs_ar_bad, obs_rready_bad); end
    checks++; if (obs_rv_cyc != 11) begin failures++; $display("FAIL bp_latency: got %0d want 11", obs_rv_cyc); end
    checks++; if (obs_pulses != 1) begin failures++; $display("FAIL bp_pulses: got %0d want 1", obs_pulses); end
    checks++; if (obs_data !== expected_line()) begin failures++; $display("FAIL bp_data: got %h want %h", obs_data, expected_line()); end
  endtask

  task automatic test_flush_midburst();
    clear_shape();
    run_refill(32'h0000_4440, 0, 1);
    checks++; if (obs_timeout || obs_ar_bad != 0 || obs_rready_bad != 0 || obs_rrdy_bad != 0) begin
      failures++; $display("FAIL flush_drain: got timeout=%0d ar_bad=%0d rready_bad=%0d rrdy_bad=%0d want 0", obs_timeout, obs_ar_bad, obs_rready_bad, obs_rrdy_bad); end
    checks++; if (obs_pulses != 0) begin failures++; $display("FAIL flush_suppress: got %0d pulses want 0", obs_pulses); end
    checks++; if (obs_rrdy_cyc != 7) begin failures++; $display("FAIL flush_rrdy_return: got %0d want 7", obs_rrdy_cyc); end
    checks++; if (obs_final !== expected_line()) begin failures++; $display("FAIL flush_rdata_written: got %h want %h", obs_final, expected_line()); end
    clear_shape();
    run_refill(32'h0000_5550, 0, -1);
    checks++; if (obs_pulses != 1 || obs_rv_cyc != 6) begin
      failures++; $display("FAIL flush_next_req: got pulses=%0d cyc=%0d want 1 6", obs_pulses, obs_rv_cyc); end
    checks++; if (obs_data !== expected_line()) begin failures++; $display("FAIL flush_next_data: got %h want %h", obs_data, expected_line()); end
  endtask

  task automatic test_flush_idle();
    int bad = 0;
    @(negedge clk);
    cpu_ren = 4'hF;
    cpu_raddr = $urandom;
    flush = 1'b1;
    @(negedge clk);
    cpu_ren = '0;
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (arvalid !== 1'b0 || dev_rrdy !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL flush_idle: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_midburst();
    @(negedge clk);
    cpu_ren = 4'h1;
    cpu_raddr = 32'h0000_1238;
    @(negedge clk);
    cpu_ren = '0;
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hDEADBEEF;
    #1;
    checks++; if (rready !== 1'b1) begin failures++; $display("FAIL rstmid_in_burst: got rready=%b want 1", rready); end
    @(negedge clk);
    rdata = 32'hCAFEF00D;
    rst = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    checks++; if (dev_rrdy !== 1'b0 || dev_rvalid !== 1'b0) begin
      failures++; $display("FAIL rstmid_dev: got rrdy=%b rvalid=%b want 0 0", dev_rrdy, dev_rvalid); end
    checks++; if (dev_rdata !== 128'h0) begin failures++; $display("FAIL rstmid_rdata: got %h want 0", dev_rdata); end
    checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || araddr !== 32'h0) begin
      failures++; $display("FAIL rstmid_axi: got arvalid=%b rready=%b araddr=%h want 0 0 0", arvalid, rready, araddr); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (dev_rrdy !== 1'b1 || arvalid !== 1'b0) begin
      failures++; $display("FAIL rstmid_release: got rrdy=%b arvalid=%b want 1 0", dev_rrdy, arvalid); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int aw, fa, exp_cyc;
    for (int i = 0; i < 20; i++) begin
      clear_shape();
      for (int j = 0; j < 4; j++) gap_cfg[j] = int'($urandom_range(0, 2));
      addr = $urandom;
      aw = int'($urandom_range(0, 3));
      fa = int'($urandom_range(0, 5)) - 1;
      run_refill(addr, aw, fa);
      exp_cyc = expected_latency(aw);
      checks++; if (obs_timeout || obs_ar_bad != 0 || obs_rready_bad != 0 || obs_rrdy_bad != 0) begin
        failures++; $display("FAIL rand_protocol[%0d]: got timeout=%0d ar_bad=%0d rready_bad=%0d rrdy_bad=%0d want 0", i, obs_timeout, obs_ar_bad, obs_rready_bad, obs_rrdy_bad); end
      checks++; if (obs_pulses != ((fa < 0) ? 1 : 0)) begin
        failures++; $display("FAIL rand_pulses[%0d]: got %0d want %0d (flush_after=%0d)", i, obs_pulses, (fa < 0) ? 1 : 0, fa); end
      checks++; if (obs_rrdy_cyc != exp_cyc + 1) begin
        failures++; $display("FAIL rand_rrdy_cyc[%0d]: got %0d want %0d", i, obs_rrdy_cyc, exp_cyc + 1); end
      checks++; if (obs_final !== expected_line()) begin
        failures++; $display("FAIL rand_line[%0d]: got %h want %h", i, obs_final, expected_line()); end
      if (fa < 0) begin
        checks++; if (obs_rv_cyc != exp_cyc || obs_data !== expected_line()) begin
          failures++; $display("FAIL rand_resp[%0d]: got cyc=%0d data=%h want cyc=%0d data=%h", i, obs_rv_cyc, obs_data, exp_cyc, expected_line()); end
      end
    end
  endtask

`ifdef ICACHE_BRIDGE_RRESP_CHK_EN
  task automatic test_rerr();
    clear_shape();
    beat_resp[2] = 2'b10;
    run_refill(32'h2000_0100, 0, -1);
    checks++; if (obs_pulses != 1 || obs_rerr !== 1'b1) begin
      failures++; $display("FAIL rerr_set: got pulses=%0d rerr=%b want 1 1", obs_pulses, obs_rerr); end
    checks++; if (obs_data !== expected_line()) begin failures++; $display("FAIL rerr_data: got %h want %h", obs_data, expected_line()); end
    clear_shape();
    run_refill(32'h2000_0200, 1, -1);
    checks++; if (obs_pulses != 1 || obs_rerr !== 1'b0) begin
      failures++; $display("FAIL rerr_clean: got pulses=%0d rerr=%b want 1 0", obs_pulses, obs_rerr); end
  endtask
`endif

  initial begin
    rst = 1'b0; flush = 1'b0; cpu_ren = '0; cpu_raddr = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    clear_shape();
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_midburst();
    test_flush_idle();
    test_reset_midburst();
    test_random();
`ifdef ICACHE_BRIDGE_RRESP_CHK_EN
    test_rerr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
